// File: rtl/deadtime_pair_gen.sv
// deadtime_pair_gen: complementary high/low gate pair with programmable dead time and trip-zone shutdown.
// Define DEADTIME_TRIP_LATCH_EN to make the trip fault sticky until the leg is disabled.
module deadtime_pair_gen #(
  parameter int         DT_WIDTH = 8,
  parameter logic [1:0] OUT_POL  = 2'b00
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic                tz_i,
  input  logic                pwm_i,
  input  logic [DT_WIDTH-1:0] deadtime_i,
  output logic [1:0]          PWM_o,
  output logic                fault_o
);
  typedef enum logic [2:0] {OFF, DT_H, H_ON, DT_L, L_ON} state_t;
  localparam logic [DT_WIDTH-1:0] ONE = {{(DT_WIDTH-1){1'b0}}, 1'b1};
  state_t state_q, state_d;
  logic [DT_WIDTH-1:0] cnt_q, cnt_d;
  logic pwm_r_q, fault_q, fault_d, gate;
  logic [1:0] out_q, out_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef DEADTIME_TRIP_LATCH_EN
    fault_d = tz_i ? 1'b1 : (enable_i ? fault_q : 1'b0);
    gate    = !fault_q;
`else
    fault_d = tz_i;
    gate    = 1'b1;
`endif
    if (tz_i || !enable_i) state_d = OFF;
    else case (state_q)
      OFF:  if (gate) begin state_d = pwm_r_q ? DT_H : DT_L; cnt_d = deadtime_i; end
      DT_H: if (!pwm_r_q) begin state_d = DT_L; cnt_d = deadtime_i; end
            else if (cnt_q == '0) state_d = H_ON;
            else cnt_d = cnt_q - ONE;
      DT_L: if (pwm_r_q) begin state_d = DT_H; cnt_d = deadtime_i; end
            else if (cnt_q == '0) state_d = L_ON;
            else cnt_d = cnt_q - ONE;
      H_ON: if (!pwm_r_q) begin state_d = DT_L; cnt_d = deadtime_i; end
      L_ON: if (pwm_r_q) begin state_d = DT_H; cnt_d = deadtime_i; end
      default: state_d = OFF;
    endcase
    out_d = (state_d == H_ON ? 2'b10 : state_d == L_ON ? 2'b01 : 2'b00) ^ OUT_POL;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= OFF;
      cnt_q   <= '0;
      pwm_r_q <= 1'b0;
      fault_q <= 1'b0;
      out_q   <= OUT_POL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pwm_r_q <= pwm_i;
      fault_q <= fault_d;
      out_q   <= out_d;
    end
  end
  assign PWM_o   = out_q;
  assign fault_o = fault_q;
endmodule

// File: tb/tb_deadtime_pair_gen.sv
// tb_deadtime_pair_gen: random and directed stimulus against a target/remaining-gap reference model.
module tb_deadtime_pair_gen;
  logic clk = 1'b0;
  logic rst, en, tz, pw;
  logic [7:0] dt;
  logic [1:0] pwm_a, pwm_b, prev_raw;
  logic flt_a, flt_b;
  int errs = 0, checks = 0;
  int m_tgt, m_rem, m_pr, m_flt;
  always #5 clk = ~clk;
  deadtime_pair_gen #(.DT_WIDTH(8), .OUT_POL(2'b00)) dut_a (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .tz_i(tz), .pwm_i(pw),
    .deadtime_i(dt), .PWM_o(pwm_a), .fault_o(flt_a));
  deadtime_pair_gen #(.DT_WIDTH(8), .OUT_POL(2'b11)) dut_b (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .tz_i(tz), .pwm_i(pw),
    .deadtime_i(dt), .PWM_o(pwm_b), .fault_o(flt_b));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  // Model: m_tgt = side being approached (0 none, 1 high, 2 low); m_rem = off cycles left, -1 once on.
  function automatic logic [1:0] m_out();
    return (m_tgt != 0 && m_rem < 0) ? (m_tgt == 1 ? 2'b10 : 2'b01) : 2'b00;
  endfunction
  task automatic model_step();
    int want;
    bit gate;
`ifdef DEADTIME_TRIP_LATCH_EN
    gate = (m_flt == 0);
`else
    gate = 1'b1;
`endif
    want = m_pr ? 1 : 2;
    if (rst) begin
      m_tgt = 0; m_rem = 0; m_pr = 0; m_flt = 0;
      return;
    end
    if (tz || !en) m_tgt = 0;
    else if (m_tgt == 0) begin
      if (gate) begin m_tgt = want; m_rem = int'(dt); end
    end else if (want != m_tgt) begin
      m_tgt = want; m_rem = int'(dt);
    end else if (m_rem > 0) m_rem--;
    else m_rem = -1;
`ifdef DEADTIME_TRIP_LATCH_EN
    m_flt = tz ? 1 : (en ? m_flt : 0);
`else
    m_flt = tz ? 1 : 0;
`endif
    m_pr = pw ? 1 : 0;
  endtask
  task automatic cyc(input logic r, input logic e, input logic t, input logic p, input int d);
    rst = r; en = e; tz = t; pw = p; dt = d[7:0];
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("pwm_pol00", pwm_a, m_out());
    chk("pwm_pol11", pwm_b, m_out() ^ 2'b11);
    chk("fault_a", flt_a, m_flt);
    chk("fault_b", flt_b, m_flt);
    chk("no_overlap_a", pwm_a == 2'b11, 0);
    chk("no_overlap_b", (pwm_b ^ 2'b11) == 2'b11, 0);
    chk("no_direct_swap", (prev_raw == 2'b10 && pwm_a == 2'b01) || (prev_raw == 2'b01 && pwm_a == 2'b10), 0);
    prev_raw = pwm_a;
  endtask
  task automatic hold(input int n, input logic e, input logic p, input int d);
    for (int i = 0; i < n; i++) cyc(1'b0, e, 1'b0, p, d);
  endtask
  initial begin
    int len, d;
    logic p;
    m_tgt = 0; m_rem = 0; m_pr = 0; m_flt = 0; prev_raw = 2'b00;
    rst = 1'b1; en = 1'b1; tz = 1'b0; pw = 1'b1; dt = 8'd5;
    @(negedge clk);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1, 5);
    chk("reset_pwm", pwm_a, 2'b00);
    chk("reset_pwm_inv", pwm_b, 2'b11);
    chk("reset_fault", flt_a, 0);
    hold(20, 1'b1, 1'b1, 5);
    chk("high_after_reset", pwm_a, 2'b10);
    hold(30, 1'b1, 1'b0, 10);
    chk("steady_low", pwm_a, 2'b01);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 10);
    chk("low_through_k", pwm_a, 2'b01);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 10);
    chk("off_at_k1", pwm_a, 2'b00);
    hold(10, 1'b1, 1'b1, 10);
    chk("off_at_k11", pwm_a, 2'b00);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 10);
    chk("high_at_k12", pwm_a, 2'b10);
    hold(3, 1'b1, 1'b0, 10);
    hold(20, 1'b1, 1'b1, 10);
    chk("high_after_reversal", pwm_a, 2'b10);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 10);
    chk("trip_off", pwm_a, 2'b00);
    chk("trip_fault", flt_a, 1);
    hold(20, 1'b1, 1'b1, 10);
    hold(1, 1'b0, 1'b1, 10);
    hold(20, 1'b1, 1'b1, 10);
    chk("high_after_recover", pwm_a, 2'b10);
    hold(6, 1'b1, 1'b0, 10);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 10);
    chk("reset_mid_dt", pwm_a, 2'b00);
    hold(20, 1'b1, 1'b0, 10);
    for (int i = 0; i < 1000; i++) cyc(1'b0, 1'b1, 1'b0, i[0], 0);
    for (int ph = 0; ph < 400; ph++) begin
      len = $urandom_range(1, 15);
      d = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 12);
      p = $urandom_range(0, 1) == 1;
      for (int i = 0; i < len; i++)
        cyc($urandom_range(0, 199) == 0, $urandom_range(0, 63) != 0, $urandom_range(0, 63) == 0, p, d);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
